// File: rtl/blink_sequencer_pkg.sv
// Shared definitions for the bike-light blink sequencer: mode encoding,
// default step durations and the duration normalisation helper.
package blink_sequencer_pkg;

    localparam int unsigned MODE_W = 2;
    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'd0;
    localparam mode_t MODE_STEADY = 2'd1;
    localparam mode_t MODE_FLASH  = 2'd2;
    localparam mode_t MODE_STROBE = 2'd3;

    localparam int unsigned DEF_CNT_W      = 9;
    localparam int unsigned DEF_FLASH_ON   = 16;
    localparam int unsigned DEF_FLASH_OFF  = 16;
    localparam int unsigned DEF_STROBE_ON  = 2;
    localparam int unsigned DEF_STROBE_GAP = 2;
    localparam int unsigned DEF_STROBE_OFF = 26;

    // Truncate a duration to the counter width; a zero-length step becomes one beat.
    function automatic int unsigned fix_dur(input int unsigned d, input int unsigned w);
        int unsigned t;
        t = (w >= 32) ? d : (d & ((32'd1 << w) - 32'd1));
        return (t == 0) ? 32'd1 : t;
    endfunction

endpackage

// File: rtl/blink_sequencer_step_timer.sv
// Loadable down-counter measuring the remaining beats of the active step.
module blink_sequencer_step_timer #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             count_en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/blink_sequencer.sv
// Bike-light pattern controller: holds the light mode and walks that mode's
// on/off step table, each step lasting a fixed number of beats.
module blink_sequencer
    import blink_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned FLASH_ON   = DEF_FLASH_ON,
    parameter int unsigned FLASH_OFF  = DEF_FLASH_OFF,
    parameter int unsigned STROBE_ON  = DEF_STROBE_ON,
    parameter int unsigned STROBE_GAP = DEF_STROBE_GAP,
    parameter int unsigned STROBE_OFF = DEF_STROBE_OFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              beat,
    input  logic              mode_next,
    output logic              light_on,
    output logic [MODE_W-1:0] mode,
    output logic [1:0]        step_idx,
    output logic              step_done
);

    // Counter reload values are duration - 1 so a step spans exactly dur beats.
    localparam logic [CNT_W-1:0] FLASH_ON_LD   = CNT_W'(fix_dur(FLASH_ON, CNT_W) - 1);
    localparam logic [CNT_W-1:0] FLASH_OFF_LD  = CNT_W'(fix_dur(FLASH_OFF, CNT_W) - 1);
    localparam logic [CNT_W-1:0] STROBE_ON_LD  = CNT_W'(fix_dur(STROBE_ON, CNT_W) - 1);
    localparam logic [CNT_W-1:0] STROBE_GAP_LD = CNT_W'(fix_dur(STROBE_GAP, CNT_W) - 1);
    localparam logic [CNT_W-1:0] STROBE_OFF_LD = CNT_W'(fix_dur(STROBE_OFF, CNT_W) - 1);

    typedef struct packed {
        logic             level;
        logic [CNT_W-1:0] dur_m1;
        logic             last;
    } step_t;

    function automatic step_t lookup(input mode_t m, input logic [1:0] s);
        step_t r;
        r.level  = 1'b0;
        r.dur_m1 = '0;
        r.last   = 1'b1;
        case ({m, s})
            {MODE_STEADY, 2'd0}: r.level = 1'b1;
            {MODE_FLASH, 2'd0}:  begin r.level = 1'b1; r.dur_m1 = FLASH_ON_LD;  r.last = 1'b0; end
            {MODE_FLASH, 2'd1}:  r.dur_m1 = FLASH_OFF_LD;
            {MODE_STROBE, 2'd0}: begin r.level = 1'b1; r.dur_m1 = STROBE_ON_LD; r.last = 1'b0; end
            {MODE_STROBE, 2'd1}: begin r.dur_m1 = STROBE_GAP_LD; r.last = 1'b0; end
            {MODE_STROBE, 2'd2}: begin r.level = 1'b1; r.dur_m1 = STROBE_ON_LD; r.last = 1'b0; end
            {MODE_STROBE, 2'd3}: r.dur_m1 = STROBE_OFF_LD;
            default: ;
        endcase
        return r;
    endfunction

    mode_t            mode_q, mode_d, tgt_mode;
    logic [1:0]       step_q, step_d, tgt_step;
    logic             light_q, light_d;
    logic             done_q, done_d;
    logic             load, count_en, cnt_zero;
    logic [CNT_W-1:0] count;
    step_t            cur, tgt;

    always_comb begin
        mode_d   = mode_q;
        step_d   = step_q;
        light_d  = light_q;
        done_d   = 1'b0;
        load     = 1'b0;
        count_en = 1'b0;
        tgt_mode = mode_q;
        tgt_step = step_q;
        cur      = lookup(mode_q, step_q);
        // A mode change swallows any coincident beat.
        if (mode_next) begin
            tgt_mode = mode_q + mode_t'(1);
            tgt_step = 2'd0;
            load     = 1'b1;
        end else if (beat) begin
            if (cnt_zero) begin
                tgt_step = cur.last ? 2'd0 : step_q + 2'd1;
                load     = 1'b1;
                done_d   = 1'b1;
            end else begin
                count_en = 1'b1;
            end
        end
        tgt = lookup(tgt_mode, tgt_step);
        if (load) begin
            mode_d  = tgt_mode;
            step_d  = tgt_step;
            light_d = tgt.level;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_OFF;
            step_q  <= 2'd0;
            light_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            light_q <= light_d;
            done_q  <= done_d;
        end
    end

    blink_sequencer_step_timer #(
        .CNT_W(CNT_W)
    ) u_step_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_value(tgt.dur_m1),
        .count_en  (count_en),
        .count     (count),
        .zero      (cnt_zero)
    );

    assign light_on  = light_q;
    assign mode      = mode_q;
    assign step_idx  = step_q;
    assign step_done = done_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed self-checking bench for blink_sequencer with default parameters.
module tb_blink_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       beat = 1'b0;
    logic       mode_next = 1'b0;
    logic       light_on;
    logic [1:0] mode;
    logic [1:0] step_idx;
    logic       step_done;

    int n_checks = 0;
    int n_fail   = 0;

    blink_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .beat     (beat),
        .mode_next(mode_next),
        .light_on (light_on),
        .mode     (mode),
        .step_idx (step_idx),
        .step_done(step_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs for one clock edge, leave them low, and sample 1 ns after the edge.
    task automatic tick(input logic b, input logic m);
        @(negedge clk);
        beat      = b;
        mode_next = m;
        @(posedge clk);
        #1;
        beat      = 1'b0;
        mode_next = 1'b0;
    endtask

    function automatic logic [31:0] cnt();
        return 32'(dut.u_step_timer.count);
    endfunction

    int exp_step;
    int exp_light;
    int exp_done;
    int n_done;

    initial begin
        #12;
        check("rst_light", 32'(light_on), 0);
        check("rst_mode", 32'(mode), 0);
        check("rst_step", 32'(step_idx), 0);
        check("rst_done", 32'(step_done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Mode wrap from reset
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b1);
            check("wrap_mode", 32'(mode), 32'(i % 4));
            check("wrap_light", 32'(light_on), (i < 4) ? 1 : 0);
            check("wrap_done", 32'(step_done), 0);
        end

        // Single-step OFF mode: every beat expires the step
        tick(1'b1, 1'b0);
        check("off_done", 32'(step_done), 1);
        check("off_step", 32'(step_idx), 0);
        check("off_light", 32'(light_on), 0);
        tick(1'b0, 1'b0);
        check("off_done_clr", 32'(step_done), 0);

        // FLASH timing, beats spaced 4 clocks apart
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("flash_mode", 32'(mode), 2);
        check("flash_light0", 32'(light_on), 1);
        check("flash_cnt0", cnt(), 15);
        n_done = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b1, 1'b0);
            exp_step  = (i / 16) % 2;
            exp_light = (exp_step == 0) ? 1 : 0;
            exp_done  = (i % 16 == 0) ? 1 : 0;
            check("flash_light", 32'(light_on), 32'(exp_light));
            check("flash_step", 32'(step_idx), 32'(exp_step));
            check("flash_done", 32'(step_done), 32'(exp_done));
            if (step_done) n_done++;
            for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        end
        check("flash_ndone", 32'(n_done), 2);
        check("flash_cnt40", cnt(), 7);

        // Run FLASH step 0 down to countdown 0, then collide mode_next with beat
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
        check("coll_pre_cnt", cnt(), 0);
        check("coll_pre_step", 32'(step_idx), 0);
        tick(1'b1, 1'b1);
        check("coll_mode", 32'(mode), 3);
        check("coll_step", 32'(step_idx), 0);
        check("coll_light", 32'(light_on), 1);
        check("coll_done", 32'(step_done), 0);
        check("coll_cnt", cnt(), 1);

        // STROBE: 2 on, 2 gap, 2 on, 26 off
        n_done = 0;
        for (int i = 1; i <= 32; i++) begin
            tick(1'b1, 1'b0);
            exp_step  = (i < 2) ? 0 : (i < 4) ? 1 : (i < 6) ? 2 : (i < 32) ? 3 : 0;
            exp_light = (exp_step == 0 || exp_step == 2) ? 1 : 0;
            exp_done  = (i == 2 || i == 4 || i == 6 || i == 32) ? 1 : 0;
            check("strobe_light", 32'(light_on), 32'(exp_light));
            check("strobe_step", 32'(step_idx), 32'(exp_step));
            check("strobe_done", 32'(step_done), 32'(exp_done));
            if (step_done) n_done++;
        end
        check("strobe_ndone", 32'(n_done), 4);

        // Hold in STROBE step 1
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("hold_pre_step", 32'(step_idx), 1);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
        check("hold_mode", 32'(mode), 3);
        check("hold_step", 32'(step_idx), 1);
        check("hold_light", 32'(light_on), 0);
        check("hold_done", 32'(step_done), 0);
        check("hold_cnt", cnt(), 1);

        // Asynchronous reset mid-FLASH, between clock edges
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        check("ar_pre_mode", 32'(mode), 2);
        check("ar_pre_light", 32'(light_on), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_light", 32'(light_on), 0);
        check("ar_mode", 32'(mode), 0);
        check("ar_step", 32'(step_idx), 0);
        check("ar_cnt", cnt(), 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
